// File: rtl/data_io_sender.sv
// data_io_sender: SPI initiator that emits a UIO file-download sequence (begin, data, end) from a valid/ready byte source
module data_io_sender #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_len,
  input  logic [7:0]  i_src_data,
  input  logic        i_src_valid,
  output logic        o_src_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_sent,
  output logic        o_spi_sck,
  output logic        o_spi_ss,
  output logic        o_spi_sdo
);
  typedef enum logic [2:0] {S_IDLE, S_T1, S_G1, S_T2, S_G2, S_T3, S_G3, S_DONE} state_t;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(SS_GAP - 1);
  state_t r_state, w_next;
  logic [15:0] r_cnt, r_len, r_sent;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit;
  logic        r_sck, r_wait, r_tail, r_first;
  logic        w_tx, w_gap, w_adv, w_phase_end, w_end, w_gap_end, w_pay;
  assign w_tx        = r_state inside {S_T1, S_T2, S_T3};
  assign w_gap       = r_state inside {S_G1, S_G2, S_G3};
  assign w_adv       = !r_wait || i_src_valid;
  assign w_phase_end = r_cnt == DIV_M1;
  assign w_end       = w_tx && r_tail && w_phase_end;
  assign w_gap_end   = w_gap && r_cnt == GAP_M1;
  assign w_pay       = r_state == S_T2 && r_sent != r_len;
  assign o_src_ready = r_wait;
  assign o_busy      = r_state != S_IDLE && r_state != S_DONE;
  assign o_done      = r_state == S_DONE;
  assign o_sent      = r_sent;
  assign o_spi_sck   = r_sck;
  assign o_spi_ss    = !w_tx;
  // the fetched byte's MSB is forwarded in its fetch cycle so SDO is stable across the whole low phase
  assign o_spi_sdo   = r_wait ? i_src_data[7] : r_shift[7];
  always_ff @(posedge i_clk) r_state <= i_reset ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_T1 : S_IDLE;
      S_T1:    w_next = w_end ? S_G1 : S_T1;
      S_G1:    w_next = w_gap_end ? (r_len == '0 ? S_T3 : S_T2) : S_G1;
      S_T2:    w_next = w_end ? S_G2 : S_T2;
      S_G2:    w_next = w_gap_end ? S_T3 : S_G2;
      S_T3:    w_next = w_end ? S_G3 : S_T3;
      S_G3:    w_next = w_gap_end ? S_DONE : S_G3;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_sent  <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_sck   <= 1'b0;
      r_wait  <= 1'b0;
      r_tail  <= 1'b0;
      r_first <= 1'b0;
    end else begin
      if (w_next != r_state) begin
        r_cnt   <= '0;
        r_sck   <= 1'b0;
        r_wait  <= 1'b0;
        r_tail  <= 1'b0;
        r_first <= 1'b1;
        r_bit   <= 3'd7;
        r_shift <= w_next == S_T2 ? 8'h54 : 8'h53;
      end else if (w_gap) begin
        r_cnt <= r_cnt + 16'd1;
      end else if (w_tx && w_adv) begin
        r_cnt <= w_phase_end ? '0 : r_cnt + 16'd1;
        if (r_wait) begin
          r_wait  <= 1'b0;
          r_shift <= i_src_data;
          r_sent  <= r_sent + 16'd1;
        end
        // a byte ends on the falling edge of its last bit; decide what follows
        if (w_phase_end && !r_tail) begin
          r_sck <= !r_sck;
          if (r_sck && r_bit == 3'd0) begin
            r_first <= 1'b0;
            r_tail  <= !(r_state == S_T2 ? w_pay : r_first);
            r_wait  <= w_pay;
            r_shift <= r_state == S_T3 ? 8'h00 : 8'h01;
            r_bit   <= 3'd7;
          end else if (r_sck) begin
            r_bit   <= r_bit - 3'd1;
            r_shift <= r_shift << 1;
          end
        end
      end
      if (r_state == S_IDLE && i_start) begin
        r_len  <= i_len;
        r_sent <= '0;
      end
    end
  end
endmodule

// File: tb/tb_data_io_sender.sv
// tb_data_io_sender: two senders (CLK_DIV 2 and 1) driving a behavioural download slave, checked against spec timing and a payload scoreboard
module tb_data_io_sender;
  typedef struct {
    int          k;
    int          len;
    int          stall;
    bit          poke;
    logic [23:0] d;
    int          exp_cyc;
    int          exp_win;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] start = '0, src_valid = '0, ready, busy, done, sck, ss, sdo;
  logic [1:0][15:0] len = '0, sent;
  logic [1:0][7:0] src_data = '0;
  int n_vec = 0, n_err = 0, rd = 0;
  logic [7:0] exp_q[$], rx_log[$], rx_pay[$];
  logic [1:0] p_sck = '0, p_ss = 2'b11, dl = '0;
  int bits[2], nb[2], addr[2], n_win = 0;
  logic [7:0] sh[2], cmd[2], ram[2][16];
  always #5 clk = ~clk;
  data_io_sender #(.CLK_DIV(2), .SS_GAP(4)) u_d2 (
    .i_clk(clk), .i_reset(rst), .i_start(start[0]), .i_len(len[0]),
    .i_src_data(src_data[0]), .i_src_valid(src_valid[0]), .o_src_ready(ready[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_sent(sent[0]),
    .o_spi_sck(sck[0]), .o_spi_ss(ss[0]), .o_spi_sdo(sdo[0]));
  data_io_sender #(.CLK_DIV(1), .SS_GAP(4)) u_d1 (
    .i_clk(clk), .i_reset(rst), .i_start(start[1]), .i_len(len[1]),
    .i_src_data(src_data[1]), .i_src_valid(src_valid[1]), .o_src_ready(ready[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_sent(sent[1]),
    .o_spi_sck(sck[1]), .o_spi_ss(ss[1]), .o_spi_sdo(sdo[1]));
  // slave: samples SDO on SCK rising, clears its bit counter while SS is high
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ss[k]) begin
        bits[k] = 0;
        nb[k] = 0;
      end else begin
        if (p_ss[k]) n_win++;
        if (sck[k] && !p_sck[k]) begin
          sh[k] = {sh[k][6:0], sdo[k]};
          if (bits[k] == 7) begin
            bits[k] = 0;
            rx_log.push_back(sh[k]);
            if (nb[k] == 0) cmd[k] = sh[k];
            else if (cmd[k] == 8'h53 && nb[k] == 1) begin
              dl[k] = sh[k][0];
              if (sh[k][0]) addr[k] = 0;
            end else if (cmd[k] == 8'h54 && dl[k]) begin
              ram[k][addr[k][3:0]] = sh[k];
              addr[k]++;
              rx_pay.push_back(sh[k]);
            end
            nb[k]++;
          end else bits[k]++;
        end
      end
      p_sck[k] = sck[k];
      p_ss[k] = ss[k];
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] pbyte(input logic [23:0] d, input int i);
    logic [23:0] t;
    t = d << (8 * i);
    return t[23:16];
  endfunction
  task automatic drain();
    while (rd < rx_pay.size()) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: got %0h expected no byte", rx_pay[rd]);
      end else check("payload", rx_pay[rd], exp_q.pop_front());
      rd++;
    end
  endtask
  task automatic run_vec(input vec_t v);
    int idx = 0, sl = v.stall, cyc = 0, nready = 0, stall_bad = 0, b0, w0;
    logic [7:0] ef[$];
    b0 = rx_log.size();
    w0 = n_win;
    @(negedge clk);
    start[v.k] = 1'b1;
    len[v.k] = 16'(v.len);
    src_valid[v.k] = 1'b1;
    src_data[v.k] = pbyte(v.d, 0);
    @(negedge clk);
    start[v.k] = 1'b0;
    cyc = 1;
    check("busy_n1", busy[v.k], 1);
    check("ss_n1", ss[v.k], 0);
    while (!done[v.k] && cyc < 2000) begin
      if (v.poke) begin
        start[v.k] = cyc == 50;
        if (cyc == 50) len[v.k] = 16'd9;
      end
      src_valid[v.k] = !(ready[v.k] && idx == 1 && sl > 0);
      if (!src_valid[v.k]) begin
        sl--;
        if (sck[v.k] || ss[v.k]) stall_bad++;
      end
      src_data[v.k] = pbyte(v.d, idx);
      if (ready[v.k]) nready++;
      if (ready[v.k] && src_valid[v.k]) begin
        exp_q.push_back(src_data[v.k]);
        idx++;
      end
      drain();
      @(negedge clk);
      cyc++;
    end
    drain();
    check("cycles", cyc, v.exp_cyc);
    check("busy_at_done", busy[v.k], 0);
    check("sent", sent[v.k], v.len);
    check("ready_cnt", nready, v.len + v.stall);
    check("stall_hold", stall_bad, 0);
    check("windows", n_win - w0, v.exp_win);
    check("sb_left", exp_q.size(), 0);
    check("slave_size", addr[v.k], v.len);
    check("downloading", dl[v.k], 0);
    for (int j = 0; j < v.len; j++) check("ram", ram[v.k][j], pbyte(v.d, j));
    ef = '{8'h53, 8'h01};
    if (v.len > 0) begin
      ef.push_back(8'h54);
      for (int j = 0; j < v.len; j++) ef.push_back(pbyte(v.d, j));
    end
    ef.push_back(8'h53);
    ef.push_back(8'h00);
    check("frame_len", rx_log.size() - b0, ef.size());
    for (int j = 0; j < ef.size(); j++)
      if (b0 + j < rx_log.size()) check("frame", rx_log[b0 + j], ef[j]);
  endtask
  initial begin
    vec_t v[6];
    int t;
    v[0] = '{0, 3, 0, 0, 24'hA500FF, 275, 3};
    v[1] = '{0, 0, 0, 0, 24'h000000, 141, 2};
    v[2] = '{0, 2, 37, 0, 24'h112200, 280, 3};
    v[3] = '{1, 2, 0, 0, 24'h3CC300, 128, 3};
    v[4] = '{1, 0, 0, 0, 24'h000000, 75, 2};
    v[5] = '{0, 2, 0, 1, 24'h9A6500, 243, 3};
    repeat (2) @(negedge clk);
    check("rst_ss", ss, 2'b11);
    check("rst_sck", sck, 0);
    check("rst_sdo", sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 0);
    check("rst_sent", sent, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(v[i]);
    @(negedge clk);
    start[0] = 1'b1;
    len[0] = 16'd3;
    src_valid[0] = 1'b1;
    src_data[0] = 8'h5A;
    @(negedge clk);
    start[0] = 1'b0;
    t = 0;
    while (sent[0] != 16'd2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("mid_sent", sent[0], 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_ss", ss[0], 1);
    check("mid_sck", sck[0], 0);
    check("mid_busy", busy[0], 0);
    check("mid_sent0", sent[0], 0);
    check("mid_ready", ready[0], 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_byte0", ram[0][0], 8'h5A);
    check("mid_dl", dl[0], 1);
    rd = rx_pay.size();
    run_vec('{0, 1, 0, 0, 24'h770000, 211, 3});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
